// File: rtl/cic_pkg.sv
// Shared CIC decimator definitions: default rates, PDM bit mapping and the
// internal register-width derivation.
package cic_pkg;

  localparam int CIC_N_STAGES = 4;
  localparam int CIC_DEC_R    = 32;
  localparam int CIC_OUT_W    = 17;

  // PDM bit values as 2-bit two's complement, sign-extended to BW by users
  localparam logic [1:0] PDM_POS = 2'b01;
  localparam logic [1:0] PDM_NEG = 2'b11;

  function automatic int cic_bw(input int n_stages, input int dec_r);
    return 2 + n_stages * $clog2(dec_r);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC comb (M = 1): out = in - in_previous, advanced only
// when the upstream stage presents a valid word.
module cic_comb_stage
  import cic_pkg::*;
#(
  parameter int W = 22
) (
  input  logic         CICCLK,
  input  logic         RST,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W-1:0] dly_q, dly_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  // next-state: difference against the delayed input, valid shifts along
  always_comb begin
    dly_d   = dly_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (in_valid) begin
      data_d  = in_data - dly_q;
      dly_d   = in_data;
      valid_d = 1'b1;
    end else begin
      data_d  = data_q;
      dly_d   = dly_q;
      valid_d = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge CICCLK or posedge RST) begin
    if (RST) begin
      dly_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dly_q   <= dly_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/cic_pdm_decimator.sv
// N-stage CIC decimator: 1-bit PDM in, OUT_W-bit signed samples out at
// 1/DEC_R of the pdm_en rate, with a settle gate on y_valid.
module cic_pdm_decimator
  import cic_pkg::*;
#(
  parameter int N_STAGES = CIC_N_STAGES,
  parameter int DEC_R    = CIC_DEC_R,
  parameter int OUT_W    = CIC_OUT_W
) (
  input  logic             CICCLK,
  input  logic             RST,
  input  logic             pdm_in,
  input  logic             pdm_en,
  output logic [OUT_W-1:0] y_out,
  output logic             y_valid,
  output logic             settled
);

  localparam int BW    = cic_bw(N_STAGES, DEC_R);
  localparam int CNT_W = $clog2(DEC_R);
  localparam int SET_W = $clog2(N_STAGES + 1);

  logic [BW-1:0]    in_s;
  logic [BW-1:0]    integ_q [N_STAGES];
  logic [BW-1:0]    integ_d [N_STAGES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_tick_s;
  logic [BW-1:0]    c0_q, c0_d;
  logic             c0_valid_q, c0_valid_d;
  logic [BW-1:0]    comb_data_s  [N_STAGES];
  logic             comb_valid_s [N_STAGES];
  logic [OUT_W-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             settled_q, settled_d;
  logic [SET_W-1:0] settle_q, settle_d;

  assign in_s = pdm_in ? {{(BW-2){PDM_POS[1]}}, PDM_POS}
                       : {{(BW-2){PDM_NEG[1]}}, PDM_NEG};

  assign dec_tick_s = pdm_en && (cnt_q == CNT_W'(DEC_R - 1));

  // integrator chain and decimation counter, all gated by pdm_en
  always_comb begin
    for (int k = 0; k < N_STAGES; k++) begin
      integ_d[k] = integ_q[k];
    end
    cnt_d = cnt_q;
    if (pdm_en) begin
      integ_d[0] = integ_q[0] + in_s;
      for (int k = 1; k < N_STAGES; k++) begin
        integ_d[k] = integ_q[k] + integ_q[k-1];
      end
      if (dec_tick_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // comb input capture: the last integrator is sampled on dec_tick
  always_comb begin
    c0_d       = c0_q;
    c0_valid_d = dec_tick_s;
    if (dec_tick_s) begin
      c0_d = integ_q[N_STAGES-1];
    end else begin
      c0_d = c0_q;
    end
  end

  for (genvar g = 0; g < N_STAGES; g++) begin : g_comb
    logic [BW-1:0] din_s;
    logic          vin_s;
    if (g == 0) begin : g_first
      assign din_s = c0_q;
      assign vin_s = c0_valid_q;
    end else begin : g_rest
      assign din_s = comb_data_s[g-1];
      assign vin_s = comb_valid_s[g-1];
    end
    cic_comb_stage #(.W(BW)) u_comb (
      .CICCLK    (CICCLK),
      .RST       (RST),
      .in_valid  (vin_s),
      .in_data   (din_s),
      .out_valid (comb_valid_s[g]),
      .out_data  (comb_data_s[g])
    );
  end

  // output truncation and settle gating: first N_STAGES updates stay silent
  always_comb begin
    y_d       = y_q;
    y_valid_d = 1'b0;
    settled_d = settled_q;
    settle_d  = settle_q;
    if (comb_valid_s[N_STAGES-1]) begin
      y_d = comb_data_s[N_STAGES-1][BW-1 -: OUT_W];
      if (settle_q == SET_W'(N_STAGES)) begin
        y_valid_d = 1'b1;
        settled_d = 1'b1;
      end else begin
        settle_d = settle_q + SET_W'(1);
      end
    end else begin
      y_valid_d = 1'b0;
    end
  end

  // state registers
  always_ff @(posedge CICCLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < N_STAGES; k++) begin
        integ_q[k] <= '0;
      end
      cnt_q      <= '0;
      c0_q       <= '0;
      c0_valid_q <= 1'b0;
      y_q        <= '0;
      y_valid_q  <= 1'b0;
      settled_q  <= 1'b0;
      settle_q   <= '0;
    end else begin
      for (int k = 0; k < N_STAGES; k++) begin
        integ_q[k] <= integ_d[k];
      end
      cnt_q      <= cnt_d;
      c0_q       <= c0_d;
      c0_valid_q <= c0_valid_d;
      y_q        <= y_d;
      y_valid_q  <= y_valid_d;
      settled_q  <= settled_d;
      settle_q   <= settle_d;
    end
  end

  assign y_out   = y_q;
  assign y_valid = y_valid_q;
  assign settled = settled_q;

endmodule

// File: tb/tb_cic_pdm_decimator.sv
// Bench for cic_pdm_decimator: a closed-form CIC model (binomial impulse
// response over the whole post-reset input history) checked every cycle.
module tb_cic_pdm_decimator;

  localparam int N     = 4;
  localparam int R     = 32;
  localparam int OUT_W = 17;
  localparam int BW    = 22;

  localparam int M_IDLE  = 0;
  localparam int M_ONES  = 1;
  localparam int M_ZEROS = 2;
  localparam int M_ALT   = 3;
  localparam int M_EVERY3 = 4;
  localparam int M_RAND  = 5;

  logic             CICCLK;
  logic             RST;
  logic             pdm_in;
  logic             pdm_en;
  logic [OUT_W-1:0] y_out;
  logic             y_valid;
  logic             settled;

  int n_total = 0;
  int n_bad   = 0;
  int mode    = M_IDLE;
  int ph      = 0;

  // model state
  int     xs[$];
  longint vh[$];
  int     pend_e[$];
  int     pend_y[$];
  int     edge_n = 0;
  int     nupd = 0;
  int     exp_y = 0;
  bit     exp_valid = 1'b0;
  bit     exp_settled = 1'b0;

  cic_pdm_decimator dut (
    .CICCLK  (CICCLK),
    .RST     (RST),
    .pdm_in  (pdm_in),
    .pdm_en  (pdm_en),
    .y_out   (y_out),
    .y_valid (y_valid),
    .settled (settled)
  );

  initial CICCLK = 1'b0;
  always #5 CICCLK = ~CICCLK;

  function automatic longint binom(input longint t, input int k);
    longint r;
    if (t < k) return 0;
    r = 1;
    for (int j = 1; j <= k; j++) r = r * (t - k + j) / j;
    return r;
  endfunction

  // Value of the last integrator after K consumed samples: sum x[n]*C(K-1-n, N-1)
  function automatic longint cap_value(input int k_cnt);
    longint s;
    s = 0;
    for (int n = 0; n < k_cnt; n++) s += longint'(xs[n]) * binom(longint'(k_cnt - 1 - n), N - 1);
    return s;
  endfunction

  // N-th difference of the decimated sequence, truncated to the top OUT_W bits
  function automatic int comb_out();
    longint   a;
    logic [63:0] b;
    logic [OUT_W-1:0] t;
    int m;
    a = 0;
    m = vh.size() - 1;
    for (int i = 0; i <= N; i++) begin
      if (m - i >= 0) begin
        if (i % 2 == 0) a += binom(longint'(N), i) * vh[m-i];
        else            a -= binom(longint'(N), i) * vh[m-i];
      end
    end
    b = a;
    t = b[BW-1 -: OUT_W];
    return int'($signed(t));
  endfunction

  task automatic drive_now();
    case (mode)
      M_ONES:   begin pdm_en = 1'b1; pdm_in = 1'b1; end
      M_ZEROS:  begin pdm_en = 1'b1; pdm_in = 1'b0; end
      M_ALT:    begin pdm_en = 1'b1; pdm_in = ph[0]; end
      M_EVERY3: begin pdm_en = (ph % 3 == 0); pdm_in = 1'b1; end
      M_RAND:   begin pdm_en = ($urandom_range(0, 3) != 0); pdm_in = 1'($urandom_range(0, 1)); end
      default:  begin pdm_en = 1'b0; pdm_in = 1'b0; end
    endcase
    ph++;
  endtask

  // stimulus driver, away from the sampling edge
  always @(posedge CICCLK) begin
    #2;
    drive_now();
  end

  // reference model: tracks consumed samples and predicts each output update
  always @(posedge CICCLK or posedge RST) begin
    if (RST) begin
      xs.delete(); vh.delete(); pend_e.delete(); pend_y.delete();
      nupd = 0; exp_y = 0; exp_valid = 1'b0; exp_settled = 1'b0;
    end else begin
      edge_n++;
      exp_valid = 1'b0;
      if (pend_e.size() > 0 && pend_e[0] == edge_n) begin
        void'(pend_e.pop_front());
        exp_y = pend_y.pop_front();
        nupd++;
        exp_valid   = (nupd > N);
        exp_settled = (nupd > N);
      end
      if (pdm_en) begin
        if (xs.size() % R == R - 1) begin
          vh.push_back(cap_value(xs.size()));
          pend_e.push_back(edge_n + N + 1);
          pend_y.push_back(comb_out());
        end
        xs.push_back(pdm_in ? 1 : -1);
      end
    end
  end

  // cycle-by-cycle compare
  always @(negedge CICCLK) begin
    n_total++;
    if (y_valid !== exp_valid || settled !== exp_settled || int'($signed(y_out)) !== exp_y) begin
      n_bad++;
      $display("FAIL cycle t=%0t: y_out=%0d y_valid=%b settled=%b, required y_out=%0d y_valid=%b settled=%b",
               $time, $signed(y_out), y_valid, settled, exp_y, exp_valid, exp_settled);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, input int maxc, output int n);
    n = 0;
    while (n < maxc) begin
      @(negedge CICCLK);
      n++;
      if (y_valid === 1'b1) return;
    end
    n_total++;
    n_bad++;
    $display("FAIL %s: no y_valid within %0d cycles", name, maxc);
  endtask

  task automatic set_mode(input int m);
    @(posedge CICCLK);
    #3;
    mode = m;
    drive_now();
  endtask

  initial begin : main
    int n;
    int prev;
    int cnt;
    RST = 1'b0; pdm_en = 1'b0; pdm_in = 1'b0;
    #1 RST = 1'b1;
    repeat (3) @(posedge CICCLK);
    @(negedge CICCLK);
    chk("reset_y_out", int'($signed(y_out)), 0);
    chk("reset_y_valid", int'(y_valid), 0);
    chk("reset_settled", int'(settled), 0);

    // release reset straight into full-scale +1
    @(posedge CICCLK);
    #3;
    RST = 1'b0;
    mode = M_ONES;
    drive_now();
    wait_valid("first_valid", 400, n);
    chk("first_valid_latency", n, 166);
    chk("ones_value", int'($signed(y_out)), 32768);
    wait_valid("ones_spacing", 100, n);
    chk("ones_spacing", n, 32);
    chk("ones_value2", int'($signed(y_out)), 32768);

    // full-scale -1, integrators wrap
    set_mode(M_ZEROS);
    repeat (8) wait_valid("zeros_run", 100, n);
    chk("zeros_value", int'($signed(y_out)), -32768);
    chk("zeros_spacing", n, 32);

    // step back to +1: monotonic ramp reaching full scale within N+1 outputs
    set_mode(M_ONES);
    prev = -32768;
    for (int i = 0; i < 5; i++) begin
      wait_valid("step_run", 100, n);
      n_total++;
      if (int'($signed(y_out)) < prev) begin
        n_bad++;
        $display("FAIL step_monotonic: got %0d after %0d", $signed(y_out), prev);
      end
      prev = int'($signed(y_out));
    end
    chk("step_final", prev, 32768);

    // pdm_en on every 3rd cycle
    set_mode(M_EVERY3);
    repeat (3) wait_valid("every3_run", 300, n);
    chk("every3_spacing", n, 96);
    chk("every3_value", int'($signed(y_out)), 32768);

    // long stall: nothing moves
    set_mode(M_IDLE);
    cnt = 0;
    repeat (200) begin
      @(negedge CICCLK);
      if (y_valid === 1'b1) cnt++;
    end
    chk("stall_no_valid", cnt, 0);
    chk("stall_hold", int'($signed(y_out)), 32768);

    // alternating input sits on a CIC null
    set_mode(M_ALT);
    repeat (8) wait_valid("alt_run", 100, n);
    chk("alt_value", int'($signed(y_out)), 0);

    // random traffic, model checks every cycle
    set_mode(M_RAND);
    repeat (3000) @(negedge CICCLK);

    // reset two cycles after a dec_tick, with the comb pipeline in flight
    set_mode(M_ONES);
    wait_valid("pre_reset_a", 200, n);
    wait_valid("pre_reset_b", 100, n);
    repeat (29) @(posedge CICCLK);
    #3;
    RST = 1'b1;
    #1;
    chk("midrst_y_out", int'($signed(y_out)), 0);
    chk("midrst_y_valid", int'(y_valid), 0);
    chk("midrst_settled", int'(settled), 0);
    @(posedge CICCLK);
    #3;
    RST = 1'b0;
    wait_valid("post_reset_valid", 400, n);
    chk("post_reset_latency", n, 166);
    chk("post_reset_value", int'($signed(y_out)), 32768);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_pdm_decimator.md
Name: cic_pdm_decimator

Overview:
- N-stage CIC decimator that converts the 1-bit PDM microphone stream into 17-bit signed samples at 1/DEC_R of the PDM rate.
- Sits directly upstream of the halfband/FIR comb chain and drives its 17-bit signed x_in.
- Integrators run at the PDM rate, gated by pdm_en.
- Combs run once per decimated sample as a short pipeline.
- Output is truncated so full-scale PDM maps exactly to ±32768.

Parameters:
- N_STAGES, 4, number of integrator and comb stages (M = 1).
- DEC_R, 32, decimation ratio. Must be a power of two and must be greater than N_STAGES+1.
- OUT_W, 17, output width in bits (signed).

Ports:
- CICCLK  in  1  block clock; every flop is on its rising edge.
- RST  in  1  reset.
- pdm_in  in  1  PDM bit. 1 maps to +1, 0 maps to -1.
- pdm_en  in  1  input-sample strobe. pdm_in is consumed only on cycles where pdm_en=1.
- y_out  out  OUT_W  signed decimated sample. Held between updates.
- y_valid  out  1  one-cycle pulse when y_out takes a new settled value.
- settled  out  1  high once the comb pipeline holds only post-reset data.

Behaviour:
- Reset: RST is asynchronous, active-high; clock is CICCLK.
  - RST clears all integrators, comb delays, comb pipeline registers, the decimation counter and the settle counter.
  - Output reset values: y_out=0, y_valid=0, settled=0.
- Internal width: BW = 2 + N_STAGES*log2(DEC_R), which is 22 at defaults.
  - All integrator and comb arithmetic is two's complement modulo 2^BW.
  - Wrap-around is intentional and is not saturated.
- Input mapping: the input sample is a BW-bit sign-extended ±1.
- Integrators: on each pdm_en=1 cycle, I1 += in and Ik += I(k-1) for k = 2..N.
  - Each stage uses the registered value of the previous stage, so there is one cycle of skew per stage. This skew is constant and has no effect on output values.
  - When pdm_en=0, all integrators hold.
- Decimation counter: counts 0..DEC_R-1, advancing on pdm_en=1 cycles only.
  - On a pdm_en=1 cycle with count = DEC_R-1, the counter wraps to 0 and raises dec_tick for one cycle.
  - On dec_tick, I_N is captured into comb input register c0.
- Comb pipeline:
  - Stage k updates one CICCLK cycle after stage k-1: ck <= c(k-1) - dk, then dk <= c(k-1).
  - Stage advance is driven by a shifting valid bit and is independent of pdm_en.
  - Because DEC_R > N_STAGES+1, a new dec_tick can never arrive while the pipeline is still busy.
- Output stage:
  - y_out <= c_N >>> (BW - OUT_W), arithmetic shift, taking bits [BW-1:BW-OUT_W].
  - Full-scale +1 input gives 2^(BW-2) >> 5 = +32768; full-scale -1 gives -32768. Both fit in 17-bit signed, so no saturation logic is needed.
- Latency: y_out updates N_STAGES+1 CICCLK cycles after the dec_tick cycle. y_valid pulses in that same cycle.
- Settling:
  - A settle counter counts output updates, saturating at N_STAGES.
  - The first N_STAGES updates still load y_out but keep y_valid=0.
  - From update N_STAGES+1 onward, settled=1 and y_valid pulses with every update.
- Input stall: pdm_en=0 for any length of time stalls the decimation counter and integrators. A comb pipeline already in flight completes normally.
- Reset mid-operation: everything returns to reset state immediately, including an in-flight comb pipeline. Settling restarts from zero.
- Same-cycle events: pdm_en=1 coinciding with the final comb stage is legal; the two paths are independent.

Decomposition:
- Shared package cic_pkg holds:
  - the BW derivation function (clog2-based);
  - the PDM-to-±1 mapping constants;
  - the default N_STAGES, DEC_R and OUT_W, which are also used by FIR_COMB's clock dividers for rate bookkeeping.
- One natural sub-module, cic_comb_stage: a single registered comb with input valid, output valid and one delay register. It is instantiated N_STAGES times in a generate loop.
- Integrators stay inline.

Test Plan:
- Constant pdm_in=1 with pdm_en=1 every cycle, checked after settled:
  - every y_valid shows y_out = +32768;
  - y_valid spacing is exactly 32 cycles;
  - the first y_valid occurs after 5 output updates (4 suppressed).
- Constant pdm_in=0: settled y_out = -32768 on every y_valid; integrators wrap without affecting the result.
- Alternating 1,0,1,0 (fs/2 lies on a CIC null): settled y_out = 0.
- pdm_en high on every 3rd cycle with pdm_in=1:
  - y_valid spacing is 96 cycles and y_out = +32768;
  - holding pdm_en=0 for 200 cycles produces no y_valid and leaves y_out unchanged.
- Step from all-0 to all-1 after settling:
  - y_out moves monotonically from -32768 to +32768 over exactly N_STAGES outputs;
  - results match a bit-exact reference model of the CIC.
- RST asserted for 1 cycle mid-pipeline, 2 cycles after dec_tick:
  - y_out=0, y_valid=0 and settled=0 immediately;
  - y_valid is next seen only after 5 fresh decimation periods;
  - no partial comb result ever appears on y_out.
